hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage datapath (IF/ID/EX/MEM/WB). Drives write-enables
//  and flushes of PC, IF_ID, ID_EX and EX_MEM: load-use stalls, taken-branch flushes
//  and multi-cycle mul/div holds. Optional EX-stage operand forwarding select.
//  Inputs come from the pipeline registers, incl. MEM_WB ins_o/reg_write.
// PARAMETERS
//  REG_AW      5   register address width
//  MD_LATENCY  32  total stall cycles per mul/div op (legal range 2..2^CNT_W-1)
//  CNT_W       16  width of md countdown and stall performance counter
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous reset, active-high
//  id_rs_i          in   REG_AW rs of instruction in ID
//  id_rt_i          in   REG_AW rt of instruction in ID
//  id_uses_rt_i     in   1      ID instruction reads rt
//  ex_rs_i, ex_rt_i in   REG_AW source regs of instruction in EX
//  ex_rd_i          in   REG_AW destination of instruction in EX
//  ex_mem_read_i    in   1      EX instruction is a load
//  ex_reg_write_i   in   1      EX instruction writes regfile
//  mem_rd_i         in   REG_AW destination in EX_MEM
//  mem_reg_write_i  in   1      EX_MEM reg_write
//  wb_rd_i          in   REG_AW destination in MEM_WB
//  wb_reg_write_i   in   1      MEM_WB reg_write
//  branch_taken_i   in   1      branch resolved taken in EX
//  md_start_i       in   1      mul/div op present in EX
//  pc_write_o       out  1      PC update enable
//  if_id_write_o    out  1      IF_ID load enable
//  if_id_flush_o    out  1      IF_ID load bubble
//  id_ex_flush_o    out  1      ID_EX load bubble (control bits zero)
//  ex_hold_o        out  1      ID_EX/EX hold (mul/div busy)
//  ex_mem_flush_o   out  1      EX_MEM load bubble
//  md_done_o        out  1      final mul/div stall cycle
//  fwd_a_o, fwd_b_o out  2      EX operand select: 00 regfile, 10 EX_MEM, 01 MEM_WB
//  stall_cnt_o      out  CNT_W  cycles with pc_write_o=0, saturating
// BEHAVIOUR
//  - rst high: state=RUN, md count=0, stall_cnt_o=0; outputs forced pc_write_o=1,
//    if_id_write_o=1, all flush/hold/md_done=0, fwd=00, regardless of inputs.
//  - Match(r,x): r!=0 && r==x; register 0 never causes stall or forward.
//  - FSM states RUN, MD_WAIT. Outputs combinational (Mealy) from state+inputs.
//  - Priority in RUN: branch_taken_i > md_start_i > data-hazard stall > none.
//  - Branch: if_id_flush_o=1, id_ex_flush_o=1 same cycle; PC loads target (pc_write_o=1).
//  - md_start_i in RUN: stall now (pc_write_o=0, if_id_write_o=0, ex_hold_o=1,
//    ex_mem_flush_o=1); count <= MD_LATENCY-2, state <= MD_WAIT.
//  - MD_WAIT: same stall outputs; count decrements; when count==0: md_done_o=1,
//    next state RUN. Total stall = MD_LATENCY cycles; md_start_i ignored in MD_WAIT.
//  - branch_taken_i cannot coincide with MD_WAIT (EX held); ignored if it does.
//  - Load-use: ex_mem_read_i && (Match(ex_rd_i,id_rs_i) || id_uses_rt_i &&
//    Match(ex_rd_i,id_rt_i)) -> pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, 1 cycle.
//  - stall_cnt_o +1 on each clk with pc_write_o=0; holds at 2^CNT_W-1.
//  - MEM_WB write to same reg is covered by write-first regfile; no stall needed.
// CONFIGURATION
//  FORWARD_EN defined: fwd_a_o = 10 if mem_reg_write_i && Match(mem_rd_i,ex_rs_i),
//    else 01 if wb_reg_write_i && Match(wb_rd_i,ex_rs_i), else 00 (EX_MEM wins);
//    fwd_b_o same with ex_rt_i. Only load-use stalls.
//  FORWARD_EN undefined: fwd_a_o=fwd_b_o=00 always; stall (as load-use) whenever
//    ID source matches ex_rd_i with ex_reg_write_i, or mem_rd_i with mem_reg_write_i.
// TESTING
//  1 Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 -> one cycle pc_write=0, id_ex_flush=1;
//    stall_cnt 0->1.
//  2 Branch: branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1, no stall count.
//  3 MD_LATENCY=4: md_start pulse -> pc_write=0 exactly 4 cycles, md_done on 4th only.
//  4 FORWARD_EN: mem_rd=wb_rd=ex_rs=5, both write -> fwd_a=10; mem write off -> 01;
//    rd=0 -> 00.
//  5 No FORWARD_EN: mem_reg_write=1, mem_rd=3, id_rt=3, uses_rt=1 -> stall 1 cycle.
//  6 rst asserted mid MD_WAIT -> outputs immediately reset values; after release, RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use/RAW stalls, branch flushes, mul/div holds.
// Optional EX-stage operand forwarding enabled by defining FORWARD_EN.
//
// state   | meaning
// RUN     | normal issue; branch, mul/div start and data hazards evaluated
// MD_WAIT | mul/div busy; front end stalled, EX held until count reaches 0
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic              branch_taken_i,
  input  logic              md_start_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_hold_o,
  output logic              ex_mem_flush_o,
  output logic              md_done_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [0:0] {RUN, MD_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] md_cnt;
  logic             hit_ex;
  logic             hit_mem;
  logic             data_stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic match(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] x);
    return (r != '0) && (r == x);
  endfunction

  always_comb begin
    hit_ex  = match(ex_rd_i, id_rs_i) || (id_uses_rt_i && match(ex_rd_i, id_rt_i));
    hit_mem = match(mem_rd_i, id_rs_i) || (id_uses_rt_i && match(mem_rd_i, id_rt_i));
`ifdef FORWARD_EN
    data_stall = ex_mem_read_i && hit_ex;
    fwd_a_sel  = (mem_reg_write_i && match(mem_rd_i, ex_rs_i)) ? 2'b10 :
                 (wb_reg_write_i  && match(wb_rd_i,  ex_rs_i)) ? 2'b01 : 2'b00;
    fwd_b_sel  = (mem_reg_write_i && match(mem_rd_i, ex_rt_i)) ? 2'b10 :
                 (wb_reg_write_i  && match(wb_rd_i,  ex_rt_i)) ? 2'b01 : 2'b00;
`else
    data_stall = ((ex_mem_read_i || ex_reg_write_i) && hit_ex) || (mem_reg_write_i && hit_mem);
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
`endif
  end

`ifndef FORWARD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs_i, ex_rt_i, wb_rd_i, wb_reg_write_i};
`endif

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_hold_o      = 1'b0;
    ex_mem_flush_o = 1'b0;
    md_done_o      = 1'b0;
    fwd_a_o        = 2'b00;
    fwd_b_o        = 2'b00;
    if (!rst) begin
      fwd_a_o = fwd_a_sel;
      fwd_b_o = fwd_b_sel;
      if (state == MD_WAIT || (!branch_taken_i && md_start_i)) begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        ex_hold_o      = 1'b1;
        ex_mem_flush_o = 1'b1;
        md_done_o      = (state == MD_WAIT) && (md_cnt == '0);
      end else if (branch_taken_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (data_stall) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      md_cnt      <= '0;
      stall_cnt_o <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!branch_taken_i && md_start_i) begin
            md_cnt <= CNT_W'(MD_LATENCY - 2);
            state  <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (md_cnt == '0) state <= RUN;
          else              md_cnt <= md_cnt - CNT_W'(1);
        end
        default: state <= RUN;
      endcase
      if (!pc_write_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LATENCY=4 and a 4-bit stall counter.
module tb_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam logic [6:0] C_IDLE  = 7'b1100000;
  localparam logic [6:0] C_DSTL  = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b1111000;
  localparam logic [6:0] C_MD    = 7'b0000110;
  localparam logic [6:0] C_MDEND = 7'b0000111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rt, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
  logic branch_taken, md_start;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, ex_mem_flush, md_done;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  wire  [6:0] ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, ex_mem_flush, md_done};

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
    .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write),
    .branch_taken_i(branch_taken), .md_start_i(md_start),
    .pc_write_o(pc_write), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush), .ex_hold_o(ex_hold), .ex_mem_flush_o(ex_mem_flush),
    .md_done_o(md_done), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_cnt_o(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_uses_rt = 0; ex_mem_read = 0; ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    branch_taken = 0; md_start = 0;
  endtask

  task automatic test_reset();
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 8; id_rs = 8; md_start = 1;
    mem_reg_write = 1; mem_rd = 5; ex_rs = 5;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_cnt !== 4'd0 || fwd_a !== 2'b00) begin
      errors++; $display("FAIL reset_cnt_fwd got %0d/%b want 0/00", stall_cnt, fwd_a);
    end
    tick();
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_hold got %b want %b", ctl, C_IDLE); end
    idle();
    rst = 0;
    tick();
    checks++;
    if (ctl !== C_IDLE || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_release got %b/%0d want %b/0", ctl, stall_cnt, C_IDLE);
    end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 8; id_rs = 8;
    #1;
    checks++;
    if (ctl !== C_DSTL) begin errors++; $display("FAIL load_use_ctl got %b want %b", ctl, C_DSTL); end
    tick();
    exp_cnt++;
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'(exp_cnt) || ctl !== C_IDLE) begin
      errors++; $display("FAIL load_use_after got %0d/%b want %0d/%b", stall_cnt, ctl, exp_cnt, C_IDLE);
    end
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs = 0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL load_use_r0 got %b want %b", ctl, C_IDLE); end
    ex_rd = 9; id_rt = 9; id_rs = 2; id_uses_rt = 0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL load_use_rt_unused got %b want %b", ctl, C_IDLE); end
    id_uses_rt = 1;
    #1;
    checks++;
    if (ctl !== C_DSTL) begin errors++; $display("FAIL load_use_rt got %b want %b", ctl, C_DSTL); end
    tick();
    exp_cnt++;
    idle();
  endtask

  task automatic test_branch();
    branch_taken = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4; id_rs = 4;
    #1;
    checks++;
    if (ctl !== C_BR) begin errors++; $display("FAIL branch_ctl got %b want %b", ctl, C_BR); end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'(exp_cnt)) begin
      errors++; $display("FAIL branch_cnt got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_md();
    md_start = 1;
    #1;
    checks++;
    if (ctl !== C_MD) begin errors++; $display("FAIL md_cycle1 got %b want %b", ctl, C_MD); end
    tick();
    for (int i = 2; i <= 4; i++) begin
      md_start = (i < 4); branch_taken = (i < 4);
      #1;
      checks++;
      if (ctl !== ((i == 4) ? C_MDEND : C_MD)) begin
        errors++; $display("FAIL md_cycle%0d got %b want %b", i, ctl, (i == 4) ? C_MDEND : C_MD);
      end
      tick();
    end
    idle();
    #1;
    exp_cnt += 4;
    checks++;
    if (ctl !== C_IDLE || stall_cnt !== 4'(exp_cnt)) begin
      errors++; $display("FAIL md_end got %b/%0d want %b/%0d", ctl, stall_cnt, C_IDLE, exp_cnt);
    end
  endtask

  task automatic test_config();
`ifdef FORWARD_EN
    mem_reg_write = 1; wb_reg_write = 1; mem_rd = 5; wb_rd = 5; ex_rs = 5; ex_rt = 5;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      errors++; $display("FAIL fwd_mem got %b/%b want 10/10", fwd_a, fwd_b);
    end
    mem_reg_write = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b want 01", fwd_a); end
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_r0 got %b want 00", fwd_a); end
    idle();
    ex_reg_write = 1; ex_rd = 7; id_rs = 7;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL fwd_no_stall got %b want %b", ctl, C_IDLE); end
    idle();
`else
    mem_reg_write = 1; mem_rd = 3; id_rt = 3; id_uses_rt = 1;
    wb_reg_write = 1; wb_rd = 6; ex_rs = 3; ex_rt = 6;
    #1;
    checks++;
    if (ctl !== C_DSTL || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL nofwd_mem got %b/%b/%b want %b/00/00", ctl, fwd_a, fwd_b, C_DSTL);
    end
    tick();
    exp_cnt++;
    idle();
    ex_reg_write = 1; ex_rd = 7; id_rs = 7;
    #1;
    checks++;
    if (ctl !== C_DSTL) begin errors++; $display("FAIL nofwd_ex got %b want %b", ctl, C_DSTL); end
    tick();
    exp_cnt++;
    idle();
    wb_reg_write = 1; wb_rd = 2; id_rs = 2;
    #1;
    checks++;
    if (ctl !== C_IDLE || stall_cnt !== 4'(exp_cnt)) begin
      errors++; $display("FAIL nofwd_wb got %b/%0d want %b/%0d", ctl, stall_cnt, C_IDLE, exp_cnt);
    end
    idle();
`endif
  endtask

  task automatic test_rst_mid_md();
    md_start = 1;
    tick();
    idle();
    #1;
    checks++;
    if (ctl !== C_MD) begin errors++; $display("FAIL rstmd_wait got %b want %b", ctl, C_MD); end
    rst = 1;
    #1;
    exp_cnt = 0;
    checks++;
    if (ctl !== C_IDLE || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL rstmd_async got %b/%0d want %b/0", ctl, stall_cnt, C_IDLE);
    end
    #2;
    rst = 0;
    #1;
    tick();
    checks++;
    if (ctl !== C_IDLE || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL rstmd_run got %b/%0d want %b/0", ctl, stall_cnt, C_IDLE);
    end
  endtask

  task automatic test_saturate();
    ex_mem_read = 1; ex_rd = 10; id_rs = 10;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", stall_cnt); end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_md();
    test_config();
    test_rst_mid_md();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
